// File: rtl/instr_mem_pkg.sv
// Shared constants, instruction type and parity helper for the instruction memory.
// The optional parity protection is enabled with INSTR_MEM_PARITY_EN.
package instr_mem_pkg;

   localparam int          DEF_WIDTH    = 32;
   localparam int          DEF_DEPTH    = 64;
   localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
   localparam int          PARITY_MAX_W = 1024;

   typedef logic [DEF_WIDTH-1:0] instr_t;

   // Callers zero-extend narrower words; padding zeros do not change parity.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x WIDTH instruction storage with synchronous write and registered read.
// With INSTR_MEM_PARITY_EN each word carries an even-parity bit checked on read.
module instr_mem_array
   import instr_mem_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
`ifdef INSTR_MEM_PARITY_EN
   output logic             rd_perr,
`endif
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   // Storage is intentionally not reset; only the read register is.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

`ifdef INSTR_MEM_PARITY_EN
   logic par_q [DEPTH];
   logic rd_par_q, rd_par_d;
   logic wr_par;

   assign wr_par = even_parity(PARITY_MAX_W'(wr_data));

   always_ff @(posedge clk) begin
      if (wr_en) begin
         par_q[wr_addr] <= wr_par;
      end
   end

   always_comb begin
      rd_par_d = rd_par_q;
      if (rd_en) begin
         rd_par_d = par_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_par_q <= 1'b0;
      end else begin
         rd_par_q <= rd_par_d;
      end
   end

   assign rd_perr = even_parity(PARITY_MAX_W'(rd_data_q)) != rd_par_q;
`endif

endmodule

// File: rtl/instr_mem_fetch.sv
// Writable instruction memory with a one-stage valid/ready fetch pipeline and range check.
// Optional per-word parity (port resp_perr) is enabled with INSTR_MEM_PARITY_EN.
module instr_mem_fetch
   import instr_mem_pkg::*;
#(
   parameter int               WIDTH    = DEF_WIDTH,
   parameter int               DEPTH    = DEF_DEPTH,
   parameter int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(DEF_NOP_WORD)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_en,
   input  logic [AW-1:0]    ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             req_valid,
   input  logic [AW-1:0]    req_addr,
   output logic             req_ready,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_instr,
   output logic [AW-1:0]    resp_addr,
`ifdef INSTR_MEM_PARITY_EN
   output logic             resp_perr,
`endif
   output logic             resp_err
);

   // Handshake: a request transfers on a clock edge where req_valid && req_ready;
   // a response transfers where resp_valid && resp_ready. Valid, once raised,
   // holds with stable data until its transfer; loads always win over fetches.

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic            resp_valid_q, resp_valid_d;
   logic [AW-1:0]   resp_addr_q, resp_addr_d;
   logic            resp_err_q, resp_err_d;
   logic            accept;
   logic            req_in_range;
   logic            ld_in_range;
   logic            wr_en;
   logic            rd_en;
   logic [WIDTH-1:0] rd_data;

   always_comb begin
      req_ready    = !reset && !ld_en && (!resp_valid_q || resp_ready);
      accept       = req_valid && req_ready;
      req_in_range = {1'b0, req_addr} < DEPTH_W;
      ld_in_range  = {1'b0, ld_addr} < DEPTH_W;
      wr_en        = ld_en && !reset && ld_in_range;
      rd_en        = accept && req_in_range;

      resp_valid_d = resp_valid_q;
      resp_addr_d  = resp_addr_q;
      resp_err_d   = resp_err_q;
      if (accept) begin
         resp_valid_d = 1'b1;
         resp_addr_d  = req_addr;
         resp_err_d   = !req_in_range;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         resp_addr_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_addr_q  <= resp_addr_d;
         resp_err_q   <= resp_err_d;
      end
   end

`ifdef INSTR_MEM_PARITY_EN
   logic rd_perr;
`endif

   instr_mem_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .rd_en   (rd_en),
      .rd_addr (req_addr),
`ifdef INSTR_MEM_PARITY_EN
      .rd_perr (rd_perr),
`endif
      .rd_data (rd_data)
   );

   // Out-of-range fetches leave the array read register untouched; substitute here.
   assign resp_valid = resp_valid_q;
   assign resp_addr  = resp_addr_q;
   assign resp_err   = resp_err_q;
   assign resp_instr = resp_err_q ? NOP_WORD : rd_data;

`ifdef INSTR_MEM_PARITY_EN
   assign resp_perr = !resp_err_q && rd_perr;
`endif

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed plus randomised bench for instr_mem_fetch (DEPTH=40) with a response scoreboard.
// Parity checks are compiled in when INSTR_MEM_PARITY_EN is defined.
module tb_instr_mem_fetch;

   localparam int WIDTH = 32;
   localparam int DEPTH = 40;
   localparam int AW    = 6;
   localparam int RW    = 1 + AW + WIDTH;
   localparam logic [WIDTH-1:0] NOP = 32'h0000_0000;

   logic             clk;
   logic             reset;
   logic             ld_en;
   logic [AW-1:0]    ld_addr;
   logic [WIDTH-1:0] ld_data;
   logic             req_valid;
   logic [AW-1:0]    req_addr;
   logic             req_ready;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_instr;
   logic [AW-1:0]    resp_addr;
   logic             resp_err;
`ifdef INSTR_MEM_PARITY_EN
   logic             resp_perr;
`endif

   instr_mem_fetch #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_instr (resp_instr),
      .resp_addr  (resp_addr),
`ifdef INSTR_MEM_PARITY_EN
      .resp_perr  (resp_perr),
`endif
      .resp_err   (resp_err)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // model and scoreboard
   logic [WIDTH-1:0] model_mem [DEPTH];
   logic [RW-1:0]    exp_q[$];
   logic [RW-1:0]    m_last;
   logic             m_valid;
   int               n_checks;
   int               n_pass;
   int               n_fail;

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic le, input logic [AW-1:0] la, input logic [WIDTH-1:0] ldat,
                        input logic rv, input logic [AW-1:0] ra, input logic rr);
      ld_en      = le;
      ld_addr    = la;
      ld_data    = ldat;
      req_valid  = rv;
      req_addr   = ra;
      resp_ready = rr;
   endtask

   // One clock: check req_ready, advance model at the edge, check response outputs.
   task automatic step();
      logic          exp_ready;
      logic          acc;
      logic [RW-1:0] e;
      #1;
      exp_ready = !reset && !ld_en && (!m_valid || resp_ready);
      chk("req_ready", RW'(req_ready), RW'(exp_ready));
      acc = req_valid && exp_ready;
      @(posedge clk);
      if (reset) begin
         exp_q.delete();
         m_valid = 1'b0;
         m_last  = '0;
      end else begin
         if (m_valid && resp_ready) void'(exp_q.pop_front());
         if (acc) begin
            if (int'(req_addr) < DEPTH) e = {1'b0, req_addr, model_mem[req_addr]};
            else                        e = {1'b1, req_addr, NOP};
            exp_q.push_back(e);
            m_last = e;
         end
         m_valid = acc || (m_valid && !resp_ready);
         if (ld_en && int'(ld_addr) < DEPTH) model_mem[ld_addr] = ld_data;
      end
      #1;
      chk("resp_valid", RW'(resp_valid), RW'(m_valid));
      if (m_valid && exp_q.size() == 0) begin
         chk("scoreboard_empty", RW'(1), RW'(0));
      end else if (m_valid) begin
         chk("resp_front", {resp_err, resp_addr, resp_instr}, exp_q[0]);
      end else begin
         chk("resp_hold", {resp_err, resp_addr, resp_instr}, m_last);
      end
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      drive(1'b1, a, d, 1'b0, '0, 1'b1);
      step();
   endtask

   task automatic fetch(input logic [AW-1:0] a, input logic rr);
      drive(1'b0, '0, '0, 1'b1, a, rr);
      step();
   endtask

   task automatic idle(input logic rr);
      drive(1'b0, '0, '0, 1'b0, '0, rr);
      step();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_fail   = 0;
      m_valid  = 1'b0;
      m_last   = '0;
      reset    = 1'b1;
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
      step();
      step();
      reset = 1'b0;

      // program load, then back-to-back fetch at full throughput
      load(6'd0, 32'h0020_0005);
      load(6'd1, 32'h00E0_0003);
      load(6'd2, 32'h1064_0027);
      fetch(6'd0, 1'b1);
      fetch(6'd1, 1'b1);
      fetch(6'd2, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // backpressure: hold three cycles, release accepts the waiting request
      fetch(6'd2, 1'b0);
      fetch(6'd0, 1'b0);
      fetch(6'd0, 1'b0);
      fetch(6'd0, 1'b0);
      fetch(6'd0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // out-of-range boundaries
      load(6'd39, 32'hCAFE_0039);
      fetch(6'd45, 1'b1);
      fetch(6'd40, 1'b1);
      fetch(6'd63, 1'b1);
      fetch(6'd39, 1'b1);
      load(6'd50, 32'hBAD0_0050);
      idle(1'b1);

      // load has priority over a waiting fetch
      drive(1'b1, 6'd3, 32'hAAAA_5555, 1'b1, 6'd3, 1'b1);
      step();
      drive(1'b1, 6'd3, 32'h1234_5678, 1'b1, 6'd3, 1'b1);
      step();
      drive(1'b1, 6'd3, 32'h0BAD_F00D, 1'b1, 6'd3, 1'b1);
      step();
      fetch(6'd3, 1'b1);
      idle(1'b1);

      // load right after the fetch of the same address keeps the registered response
      load(6'd4, 32'h4444_4444);
      fetch(6'd4, 1'b0);
      drive(1'b1, 6'd4, 32'h5555_5555, 1'b0, '0, 1'b0);
      step();
      idle(1'b0);
      idle(1'b1);
      fetch(6'd4, 1'b1);
      idle(1'b1);

      // reset while a response is stalled; load during reset must not land
      load(6'd5, 32'h1111_1111);
      fetch(6'd2, 1'b0);
      idle(1'b0);
      reset = 1'b1;
      drive(1'b1, 6'd5, 32'h2222_2222, 1'b1, 6'd2, 1'b0);
      step();
      reset = 1'b0;
      idle(1'b1);
      fetch(6'd5, 1'b1);
      idle(1'b1);

      // randomised traffic over the full AW address space
      for (int a = 0; a < DEPTH; a++) load(AW'(a), $urandom);
      for (int i = 0; i < 200; i++) begin
         drive(($urandom_range(0, 7) == 0), AW'($urandom_range(0, 63)), $urandom,
               $urandom_range(0, 1) == 1, AW'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
         step();
      end
      idle(1'b1);
      idle(1'b1);

`ifdef INSTR_MEM_PARITY_EN
      load(6'd0, 32'h0020_0005);
      load(6'd1, 32'h00E0_0003);
      idle(1'b1);
      dut.u_array.mem_q[1] = dut.u_array.mem_q[1] ^ 32'h0000_0008;
      model_mem[1] = model_mem[1] ^ 32'h0000_0008;
      fetch(6'd1, 1'b1);
      chk("perr_flip", RW'(resp_perr), RW'(1));
      fetch(6'd0, 1'b1);
      chk("perr_clean", RW'(resp_perr), RW'(0));
      fetch(6'd45, 1'b1);
      chk("perr_oor", RW'(resp_perr), RW'(0));
      idle(1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
